// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF / LS request-response channels and the shared memory port
// that surround mem_port_arbiter.
//   master : the core requesters plus the memory read-data return (environment side)
//   slave  : the arbiter itself
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Instruction-fetch requester (read only)
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  // Load/store requester
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_wr_en;
  logic [DATA_W-1:0] ls_wr_data;
  logic [BE_W-1:0]   ls_byte_en;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;

  // Shared single-port synchronous memory
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic [BE_W-1:0]   mem_byte_en;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_addr, ls_wr_en, ls_wr_data, ls_byte_en,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_en, mem_addr, mem_wr_en, mem_wr_data, mem_byte_en,
    output mem_rd_data
  );

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_addr, ls_wr_en, ls_wr_data, ls_byte_en,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_en, mem_addr, mem_wr_en, mem_wr_data, mem_byte_en,
    input  mem_rd_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch (IF) and load/store (LS) requesters, one transaction in flight.
//
// Transaction flow: IDLE (handshake) -> ISSUE (one mem_en cycle) -> WAIT
// (MEM_LATENCY-1 cycles, skipped for MEM_LATENCY=1) -> RESP (one rsp_valid pulse).
//
// Optional build macro MEM_PORT_ARB_RR_EN:
//   defined   - round-robin arbitration on simultaneous requests (1-bit last_grant)
//   undefined - fixed priority, LS wins over IF
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1,   // ISSUE cycle to mem_rd_data valid, >= 1
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;

  // Captured request; these registers drive the memory port directly, so the
  // memory sees stable fields from ISSUE until the next capture.
  logic              grant_ls_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [BE_W-1:0]   byte_en_q;

  // Registered strobes
  logic              mem_en_q;
  logic              if_rsp_valid_q;
  logic              ls_rsp_valid_q;

  // Arbitration
  logic              prio_ls;   // 1: LS wins a tie
  logic              win_ls;
  logic              win_if;
  logic              accept_ok;
  logic              hs_ls;
  logic              hs_if;

`ifdef MEM_PORT_ARB_RR_EN
  // Remembers who won the previous handshake; 0 = IF, 1 = LS.
  logic              last_grant_ls;

  // Track the last granted requester so a tie goes to the other one.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_ls <= 1'b0;
    end else if (hs_ls || hs_if) begin
      last_grant_ls <= hs_ls;
    end
  end

  assign prio_ls = !last_grant_ls;
`else
  assign prio_ls = 1'b1;
`endif

  // Pick the winner among the valid requesters; only offered in IDLE and out of reset.
  // NOTE: every signal assigned here gets a value on every path (defaults first),
  // otherwise the tool infers a latch to hold the old value.
  always_comb begin
    accept_ok = 1'b0;
    win_ls    = 1'b0;
    win_if    = 1'b0;
    accept_ok = (state == S_IDLE) && rst_n;
    win_ls    = bus.ls_req_valid && (!bus.if_req_valid || prio_ls);
    win_if    = bus.if_req_valid && !win_ls;
  end

  assign bus.ls_req_ready = accept_ok && win_ls;
  assign bus.if_req_ready = accept_ok && win_if;
  assign hs_ls            = bus.ls_req_valid && bus.ls_req_ready;
  assign hs_if            = bus.if_req_valid && bus.if_req_ready;

  // Transaction FSM: capture on handshake, strobe the memory once, count out
  // the memory latency, then pulse the granted requester's response.
  // NOTE: reset is asynchronous and clears every register here, including the
  // captured request, so the memory port reads all-zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      grant_ls_q     <= 1'b0;
      addr_q         <= '0;
      wr_en_q        <= 1'b0;
      wr_data_q      <= '0;
      byte_en_q      <= '0;
      mem_en_q       <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      mem_en_q       <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (hs_ls) begin
            grant_ls_q <= 1'b1;
            addr_q     <= bus.ls_addr;
            wr_en_q    <= bus.ls_wr_en;
            wr_data_q  <= bus.ls_wr_data;
            byte_en_q  <= bus.ls_byte_en;
            mem_en_q   <= 1'b1;
            state      <= S_ISSUE;
          end else if (hs_if) begin
            // Fetches are always full-word reads.
            grant_ls_q <= 1'b0;
            addr_q     <= bus.if_addr;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            byte_en_q  <= '1;
            mem_en_q   <= 1'b1;
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wait_cnt <= CNT_W'(MEM_LATENCY - 1);
          if (MEM_LATENCY == 1) begin
            if_rsp_valid_q <= !grant_ls_q;
            ls_rsp_valid_q <= grant_ls_q;
            state          <= S_RESP;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (wait_cnt == CNT_W'(1)) begin
            if_rsp_valid_q <= !grant_ls_q;
            ls_rsp_valid_q <= grant_ls_q;
            state          <= S_RESP;
          end
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory port straight from the capture registers.
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.mem_byte_en = byte_en_q;

  // Read data arrives from the memory during RESP itself, so the response data
  // is steered combinationally and forced to 0 outside the pulse and for stores.
  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.ls_rsp_valid = ls_rsp_valid_q;
  assign bus.if_rsp_data  = if_rsp_valid_q ? bus.mem_rd_data : '0;
  assign bus.ls_rsp_data  = (ls_rsp_valid_q && !wr_en_q) ? bus.mem_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with MEM_LATENCY 1, 2 and 3
// (index k = latency-1), each with its own memory model. A monitor pushes the
// expected response on every observed handshake and pops/compares it when a
// response appears; directed steps check grant order, timing and reset.
module tb_mem_port_arbiter;

  typedef struct {
    bit          ls;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  // Per-instance stimulus
  logic        ifv  [3];
  logic [31:0] ifa  [3];
  logic        lsv  [3];
  logic [31:0] lsa  [3];
  logic        lswe [3];
  logic [31:0] lswd [3];
  logic [3:0]  lsbe [3];

  // Per-instance observed outputs
  logic        ifr  [3];
  logic        lsr  [3];
  logic        ifrv [3];
  logic [31:0] ifrd [3];
  logic        lsrv [3];
  logic [31:0] lsrd [3];
  logic        men  [3];
  logic [31:0] maddr[3];
  logic        mwe  [3];
  logic [31:0] mwd  [3];
  logic [3:0]  mbe  [3];

  // Scoreboard and logs
  exp_t sbq      [3][$];
  bit   gl       [3][$];  // grant log, 1 = LS
  int   hq       [3][$];  // handshake cycles
  int   last_men [3];

  function automatic logic [31:0] pat(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return (a ^ 32'h5A5A_0000) + 32'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    logic [2:0]  sr_en;
    logic [31:0] sr_addr [3];

    // Memory model: read data for an ISSUE at cycle t is valid only in cycle t+L.
    always @(posedge clk) begin
      sr_en      <= {sr_en[1:0], bus.mem_en};
      sr_addr[2] <= sr_addr[1];
      sr_addr[1] <= sr_addr[0];
      sr_addr[0] <= bus.mem_addr;
    end
    assign bus.mem_rd_data = (sr_en[g] === 1'b1) ? pat(sr_addr[g]) : 32'hBAD0_BAD0;

    assign bus.if_req_valid = ifv[g];
    assign bus.if_addr      = ifa[g];
    assign bus.ls_req_valid = lsv[g];
    assign bus.ls_addr      = lsa[g];
    assign bus.ls_wr_en     = lswe[g];
    assign bus.ls_wr_data   = lswd[g];
    assign bus.ls_byte_en   = lsbe[g];

    assign ifr[g]   = bus.if_req_ready;
    assign lsr[g]   = bus.ls_req_ready;
    assign ifrv[g]  = bus.if_rsp_valid;
    assign ifrd[g]  = bus.if_rsp_data;
    assign lsrv[g]  = bus.ls_rsp_valid;
    assign lsrd[g]  = bus.ls_rsp_data;
    assign men[g]   = bus.mem_en;
    assign maddr[g] = bus.mem_addr;
    assign mwe[g]   = bus.mem_wr_en;
    assign mwd[g]   = bus.mem_wr_data;
    assign mbe[g]   = bus.mem_byte_en;

    mem_port_arbiter #(
      .MEM_LATENCY (g + 1),
      .ADDR_W      (32),
      .DATA_W      (32)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  // Monitor: scoreboard push on handshake, pop/compare on response.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        sbq[k].delete();
        last_men[k] = -100;
      end else begin
        check($sformatf("one_ready_k%0d", k), 32'($countones({ifr[k], lsr[k]}) <= 1), 32'd1);
        if (lsv[k] && lsr[k]) begin
          e.ls   = 1'b1;
          e.data = lswe[k] ? 32'h0 : pat(lsa[k]);
          e.cyc  = cyc + 2 + k;
          sbq[k].push_back(e);
          gl[k].push_back(1'b1);
          hq[k].push_back(cyc);
        end else if (ifv[k] && ifr[k]) begin
          e.ls   = 1'b0;
          e.data = pat(ifa[k]);
          e.cyc  = cyc + 2 + k;
          sbq[k].push_back(e);
          gl[k].push_back(1'b0);
          hq[k].push_back(cyc);
        end
        if (men[k]) begin
          check($sformatf("men_gap_k%0d", k), 32'((cyc - last_men[k]) >= k + 3), 32'd1);
          last_men[k] = cyc;
        end
        if (ifrv[k] || lsrv[k]) begin
          if (sbq[k].size() == 0) begin
            check($sformatf("rsp_unexpected_k%0d", k), 32'(sbq[k].size()), 32'd1);
          end else begin
            e = sbq[k].pop_front();
            check($sformatf("rsp_ls_k%0d", k), 32'(lsrv[k]), 32'(e.ls));
            check($sformatf("rsp_if_k%0d", k), 32'(ifrv[k]), 32'(!e.ls));
            check($sformatf("rsp_data_k%0d", k), e.ls ? lsrd[k] : ifrd[k], e.data);
            check($sformatf("rsp_cycle_k%0d", k), 32'(cyc), 32'(e.cyc));
          end
        end
        if (!ifrv[k]) check($sformatf("if_data_idle_k%0d", k), ifrd[k], 32'h0);
        if (!lsrv[k]) check($sformatf("ls_data_idle_k%0d", k), lsrd[k], 32'h0);
      end
    end
  end

  initial begin
    int c0;
    int n0;
    bit exp_gl [4];

`ifdef MEM_PORT_ARB_RR_EN
    exp_gl = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_gl = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ifv[k] = 1'b0; ifa[k] = '0; lsv[k] = 1'b0; lsa[k] = '0;
      lswe[k] = 1'b0; lswd[k] = '0; lsbe[k] = '0; last_men[k] = -100;
    end

    // Reset state: valids high during reset must not see ready.
    ifv[0] = 1'b1; lsv[0] = 1'b1; ifa[0] = 32'h10; lsa[0] = 32'h20;
    repeat (3) @(negedge clk);
    check("rst_if_ready", 32'(ifr[0]), 32'd0);
    check("rst_ls_ready", 32'(lsr[0]), 32'd0);
    check("rst_mem_en", 32'(men[0]), 32'd0);
    check("rst_mem_addr", maddr[0], 32'h0);
    check("rst_mem_be", 32'(mbe[0]), 32'h0);
    check("rst_if_rsp", 32'(ifrv[0]), 32'd0);
    check("rst_ls_rsp", 32'(lsrv[0]), 32'd0);
    ifv[0] = 1'b0; lsv[0] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // IF read, L=1, addr 0x100.
    @(posedge clk); #2;
    ifv[0] = 1'b1; ifa[0] = 32'h100;
    @(negedge clk);
    check("t1_if_ready", 32'(ifr[0]), 32'd1);
    check("t1_ls_ready", 32'(lsr[0]), 32'd0);
    @(posedge clk); #2;
    ifv[0] = 1'b0;
    @(negedge clk);
    check("t1_mem_en", 32'(men[0]), 32'd1);
    check("t1_mem_addr", maddr[0], 32'h100);
    check("t1_mem_wr_en", 32'(mwe[0]), 32'd0);
    check("t1_mem_be", 32'(mbe[0]), 32'hF);
    @(negedge clk);
    check("t1_rsp_valid", 32'(ifrv[0]), 32'd1);
    check("t1_rsp_data", ifrd[0], 32'hDEAD_BEEF);
    @(negedge clk);
    check("t1_rsp_end", 32'(ifrv[0]), 32'd0);
    check("t1_mem_en_end", 32'(men[0]), 32'd0);
    check("t1_addr_hold", maddr[0], 32'h100);

    // LS store, L=1.
    @(posedge clk); #2;
    lsv[0] = 1'b1; lswe[0] = 1'b1; lsa[0] = 32'h40; lswd[0] = 32'h1234_5678; lsbe[0] = 4'b0011;
    @(negedge clk);
    check("t2_ls_ready", 32'(lsr[0]), 32'd1);
    @(posedge clk); #2;
    lsv[0] = 1'b0; lswe[0] = 1'b0;
    @(negedge clk);
    check("t2_mem_en", 32'(men[0]), 32'd1);
    check("t2_mem_wr_en", 32'(mwe[0]), 32'd1);
    check("t2_mem_addr", maddr[0], 32'h40);
    check("t2_mem_wr_data", mwd[0], 32'h1234_5678);
    check("t2_mem_be", 32'(mbe[0]), 32'h3);
    @(negedge clk);
    check("t2_ls_rsp", 32'(lsrv[0]), 32'd1);
    check("t2_ls_data", lsrd[0], 32'h0);
    check("t2_if_rsp", 32'(ifrv[0]), 32'd0);

    // Back-to-back LS loads, L=2: handshakes 4 cycles apart.
    @(posedge clk); #2;
    lsv[1] = 1'b1; lsa[1] = 32'h80; lswe[1] = 1'b0;
    n0 = hq[1].size();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (hq[1].size() >= n0 + 3) break;
    end
    @(posedge clk); #2;
    lsv[1] = 1'b0;
    check("t4_hs_count", 32'(hq[1].size()), 32'(n0 + 3));
    if (hq[1].size() >= n0 + 3) begin
      check("t4_gap0", 32'(hq[1][n0+1] - hq[1][n0]), 32'd4);
      check("t4_gap1", 32'(hq[1][n0+2] - hq[1][n0+1]), 32'd4);
    end
    repeat (8) @(negedge clk);

    // Simultaneous requests, L=3, four grants.
    @(posedge clk); #2;
    ifv[2] = 1'b1; ifa[2] = 32'h300;
    lsv[2] = 1'b1; lsa[2] = 32'h340; lswe[2] = 1'b0;
    n0 = gl[2].size();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (gl[2].size() >= n0 + 4) break;
    end
    @(posedge clk); #2;
    ifv[2] = 1'b0; lsv[2] = 1'b0;
    check("t3_grant_count", 32'(gl[2].size()), 32'(n0 + 4));
    if (gl[2].size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("t3_grant%0d", i), 32'(gl[2][n0+i]), 32'(exp_gl[i]));
    end
    repeat (10) @(negedge clk);

    // Request raised during WAIT (L=3): ready held 0 until IDLE.
    @(posedge clk); #2;
    ifv[2] = 1'b1; ifa[2] = 32'h310;
    @(negedge clk);
    check("t6_if_ready", 32'(ifr[2]), 32'd1);
    @(posedge clk); #2;
    ifv[2] = 1'b0;
    @(posedge clk); #2;
    lsv[2] = 1'b1; lsa[2] = 32'h320; lswe[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t6_busy_ready%0d", i), 32'(lsr[2]), 32'd0);
    end
    @(negedge clk);
    check("t6_idle_ready", 32'(lsr[2]), 32'd1);
    @(posedge clk); #2;
    lsv[2] = 1'b0;
    repeat (10) @(negedge clk);

    // Reset pulsed during WAIT (L=3): dropped request, immediate re-accept.
    @(posedge clk); #2;
    ifv[2] = 1'b1; ifa[2] = 32'h330;
    @(negedge clk);
    check("t5_if_ready", 32'(ifr[2]), 32'd1);
    @(posedge clk); #2;
    ifv[2] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    ifv[2] = 1'b1; ifa[2] = 32'h200;
    @(negedge clk);
    check("t5_rst_if_ready", 32'(ifr[2]), 32'd0);
    check("t5_rst_ls_ready", 32'(lsr[2]), 32'd0);
    check("t5_rst_mem_en", 32'(men[2]), 32'd0);
    check("t5_rst_mem_addr", maddr[2], 32'h0);
    check("t5_rst_mem_be", 32'(mbe[2]), 32'h0);
    check("t5_rst_mem_wr", 32'(mwe[2]), 32'd0);
    check("t5_rst_if_rsp", 32'(ifrv[2]), 32'd0);
    check("t5_rst_if_data", ifrd[2], 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_accept_after_rst", 32'(ifr[2]), 32'd1);
    @(posedge clk); #2;
    ifv[2] = 1'b0;
    repeat (12) @(negedge clk);

    for (int k = 0; k < 3; k++)
      check($sformatf("sb_drain_k%0d", k), 32'(sbq[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
